// File: rtl/secp256k1_mult_mod_serial.sv
// Bit-serial modular multiplier for secp256k1: returns a*b mod p or a*b mod n,
// consuming one bit of b per cycle, MSB first, with a single outstanding request.
module secp256k1_mult_mod_serial (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [511:0] i_mult_dat,
    input  logic [15:0]  i_mult_ctl,
    input  logic         i_mult_val,
    output logic         i_mult_rdy,
    output logic [255:0] o_mult_dat,
    output logic [15:0]  o_mult_ctl,
    output logic         o_mult_val,
    input  logic         o_mult_rdy,
    output logic         o_mult_sop,
    output logic         o_mult_eop,
    output logic         o_mult_err,
    output logic [4:0]   o_mult_mod
);

    localparam logic [255:0] P_MOD = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] N_MOD = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

    typedef enum logic [1:0] {IDLE, LOAD, MUL, DONE} state_t;

    state_t         state_r, state_s;
    logic [255:0]   a_r, b_r, acc_r;
    logic [15:0]    ctl_r;
    logic [7:0]     cnt_r;
    logic           rdy_r, val_r, err_r;
    logic [255:0]   dat_r;
    logic [15:0]    octl_r;

    logic           bad_sel_s;
    logic [255:0]   m_s, a_red_s, dbl_red_s, nxt_s;
    logic [256:0]   dbl_s, add_s;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_mult_val && rdy_r) state_s = LOAD;
                else                     state_s = IDLE;
            end
            LOAD: begin
                if (bad_sel_s) state_s = DONE;
                else           state_s = MUL;
            end
            MUL: begin
                if (cnt_r == 8'd0) state_s = DONE;
                else               state_s = MUL;
            end
            DONE: begin
                if (o_mult_rdy) state_s = IDLE;
                else            state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // One double-and-add step; the 257th bit only matters for the compares.
    always_comb begin
        bad_sel_s = ctl_r[7];
        m_s       = ctl_r[6] ? N_MOD : P_MOD;
        if (a_r >= m_s) a_red_s = a_r - m_s;
        else            a_red_s = a_r;
        dbl_s = {acc_r, 1'b0};
        if (dbl_s >= {1'b0, m_s}) dbl_red_s = dbl_s[255:0] - m_s;
        else                      dbl_red_s = dbl_s[255:0];
        if (b_r[cnt_r]) add_s = {1'b0, dbl_red_s} + {1'b0, a_r};
        else            add_s = {1'b0, dbl_red_s};
        if (add_s >= {1'b0, m_s}) nxt_s = add_s[255:0] - m_s;
        else                      nxt_s = add_s[255:0];
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_r    <= 256'd0;
            b_r    <= 256'd0;
            acc_r  <= 256'd0;
            ctl_r  <= 16'd0;
            cnt_r  <= 8'd0;
            rdy_r  <= 1'b0;
            val_r  <= 1'b0;
            err_r  <= 1'b0;
            dat_r  <= 256'd0;
            octl_r <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_mult_val && rdy_r) begin
                        a_r   <= i_mult_dat[255:0];
                        b_r   <= i_mult_dat[511:256];
                        ctl_r <= i_mult_ctl;
                        rdy_r <= 1'b0;
                    end else begin
                        rdy_r <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bad_sel_s) begin
                        dat_r  <= 256'd0;
                        octl_r <= ctl_r;
                        err_r  <= 1'b1;
                        val_r  <= 1'b1;
                    end else begin
                        a_r   <= a_red_s;
                        acc_r <= 256'd0;
                        cnt_r <= 8'd255;
                    end
                end
                MUL: begin
                    acc_r <= nxt_s;
                    cnt_r <= cnt_r - 8'd1;
                    if (cnt_r == 8'd0) begin
                        dat_r  <= nxt_s;
                        octl_r <= ctl_r;
                        err_r  <= 1'b0;
                        val_r  <= 1'b1;
                    end
                end
                DONE: begin
                    if (o_mult_rdy) begin
                        val_r <= 1'b0;
                        rdy_r <= 1'b1;
                    end
                end
                default: begin
                    rdy_r <= 1'b0;
                    val_r <= 1'b0;
                end
            endcase
        end
    end

    assign i_mult_rdy = rdy_r;
    assign o_mult_val = val_r;
    assign o_mult_dat = dat_r;
    assign o_mult_ctl = octl_r;
    assign o_mult_err = err_r;
    assign o_mult_sop = 1'b1;
    assign o_mult_eop = 1'b1;
    assign o_mult_mod = 5'd0;

endmodule

// File: doc/secp256k1_mult_mod_serial.md
# secp256k1_mult_mod_serial

Bit-serial modular multiplier that acts as the responder on the 256-bit multiplier stream used by the secp256k1 point arithmetic blocks (point doubling, point addition). It accepts one operand pair `a`, `b` per request and returns `a*b mod m`, where `m` is the field prime `p` or the group order `n`, selected per request by `ctl[7:6]`. The full 16-bit `ctl` is echoed back unchanged so the initiator can route each result to its equation slot. Single outstanding request; area-optimised, 1 bit of `b` per cycle.

## Interface
- No parameters. Moduli `p` and `n` come from `secp256k1_pkg`.
- `i_clk` in 1: clock; one clock domain.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_mult_if` sink, `if_axi_stream` (DAT_BYTS=64, CTL_BITS=16): request stream.
  - `dat[255:0]` is `a`; `dat[511:256]` is `b`.
  - `ctl[7:6]` selects the modulus: 0 = `p`, 1 = `n`, 2 and 3 are invalid.
  - `sop`, `eop`, `err` and `mod` are ignored.
- `o_mult_if` source, `if_axi_stream` (DAT_BYTS=32, CTL_BITS=16): result stream.
  - `dat[255:0]` is the result; `ctl` is the echoed request `ctl`.
  - `sop` = `eop` = 1 and `mod` = 0, driven combinationally.
  - `err` = 1 for an invalid modulus select.

## Operation
- States: IDLE, LOAD, MUL, DONE.
- IDLE:
  - `i_mult_if.rdy` = 1.
  - On the handshake (`val && rdy`) at edge k: capture `a`, `b`, `ctl`; drop `rdy`; go to LOAD.
- LOAD (edge k+1):
  - If `ctl[7:6]` >= 2: `o_mult_if.dat` <= 0, `err` <= 1, `val` <= 1; go to DONE.
  - Otherwise: `a` <= (`a` >= m ? `a` − m : `a`); R <= 0; bit counter <= 255; go to MUL.
  - One conditional subtract always fully reduces `a`, because `a` < 2^256 < 2m for both moduli.
  - `b` is not reduced; its raw bits are consumed.
- MUL, one iteration per edge, counter i from 255 down to 0:
  - T = 2R; if T >= m then T = T − m.
  - If `b[i]`: T = T + `a`; if T >= m then T = T − m.
  - R <= T.
  - All intermediate values are 257 bits wide; R is always < m.
- At the edge where i = 0: `o_mult_if.dat` <= final T, `ctl` <= captured `ctl`, `err` <= 0, `val` <= 1; go to DONE.
- DONE:
  - Hold `o_mult_if.val`, `dat`, `ctl` and `err` stable until `o_mult_if.rdy`.
  - On the output handshake: `val` <= 0, `i_mult_if.rdy` <= 1; go to IDLE.
- Result is always the canonical residue in [0, m−1].
- No queueing: `i_mult_if.rdy` is 0 in every state except IDLE.

## Timing
- Reset values: `o_mult_if.val`, `dat`, `ctl`, `err` = 0; `i_mult_if.rdy` = 0; state = IDLE.
  - `i_mult_if.rdy` rises on the first clock edge after `i_rst` deasserts.
- Latency, valid modulus: request accepted at edge k → `o_mult_if.val` rises at edge k+257.
  - 1 LOAD cycle plus 256 MUL cycles.
- Latency, invalid modulus: `o_mult_if.val` with `err` = 1 rises at edge k+1.
- Output handshake at edge j → `i_mult_if.rdy` = 1 from edge j+1.
  - Minimum request spacing is 259 cycles.
- Backpressure: while `o_mult_if.rdy` = 0 in DONE, outputs hold indefinitely and no request is accepted.
- Reset mid-operation (any state): asynchronously returns every output and all state to reset values.
  - The in-flight request is discarded; no partial result is ever emitted.
- `i_mult_if.val` while `rdy` = 0: ignored; the initiator must hold the request.
- Operands equal to 0, `a` = m, or `b` >= m are legal and yield correct residues.

## Test plan
- `a` = 3, `b` = 5, `ctl` = 0x0007 → `dat` = 15, `ctl` = 0x0007, `err` = 0; `val` rises exactly 257 edges after the accept edge.
- `a` = p−1, `b` = p−1, `ctl` = 0x0000 → `dat` = 1. Then `a` = 0, `b` = 2^256−1 → `dat` = 0.
- Unreduced operands, `ctl` = 0x0001:
  - `a` = p+1, `b` = 2 → `dat` = 2.
  - `a` = 5, `b` = p+3 → `dat` = 15.
- `ctl` = 0x0045 (mod `n`), `a` = n−1, `b` = 2 → `dat` = n−2, `ctl` = 0x0045.
  - Same operands with `ctl` = 0x0005 (mod `p`) → `dat` = (2n−2) mod p.
- `ctl` = 0x00C9 → `err` = 1, `dat` = 0, `ctl` = 0x00C9; `val` rises 1 edge after accept.
- Backpressure: hold `o_mult_if.rdy` = 0 for 10 cycles after `val` → `dat` and `ctl` stable and `i_mult_if.rdy` = 0 throughout; release → next request accepted one cycle later.
- Reset mid-operation: assert `i_rst` at MUL iteration 100 → all outputs 0 immediately; after release, a new request `a` = 7, `b` = 6 → `dat` = 42.
- Random regression: 10k operand pairs, random `ctl` and random `rdy` stalls, compared against a reference model computing `a*b mod m`.
